// File: rtl/seg_pkg.sv
// Shared segment-display constants used by the segment decoder and the scan driver.
package seg_pkg;

    localparam logic [8:0] SEG_ZERO  = 9'h03f;
    localparam logic [8:0] SEG_BLANK = 9'h000;

    localparam logic SLOT_UNITS = 1'b0;
    localparam logic SLOT_TENS  = 1'b1;

    localparam logic [1:0] DIG_OFF   = 2'b11;
    localparam logic [1:0] DIG_UNITS = 2'b10;
    localparam logic [1:0] DIG_TENS  = 2'b01;

    // Active-low digit select for the digit being scanned.
    function automatic logic [1:0] dig_select(input logic slot);
        return (slot == SLOT_TENS) ? DIG_TENS : DIG_UNITS;
    endfunction

endpackage

// File: rtl/seg_scan_driver_timebase.sv
// Scan timing for the two-digit display: slot counter, PWM sub-slot index,
// digit slot, frame counter and free-running blink phase.
module scan_timebase
    import seg_pkg::*;
#(
    parameter int CLK_HZ       = 12000000,
    parameter int SCAN_HZ      = 1000,
    parameter int DEAD_CYC     = 12,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       clk,
    input  logic       rst,
    output logic       frame_start,
    output logic       dead,
    output logic [3:0] sub_idx,
    output logic       slot,
    output logic       blink_ph
);

    localparam int SLOT_CYC = CLK_HZ / SCAN_HZ;
    localparam int SUB_CYC  = SLOT_CYC / 16;
    localparam int SLOT_W   = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int SUB_W    = (SUB_CYC > 1) ? $clog2(SUB_CYC) : 1;
    localparam int FRAME_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    if ((SLOT_CYC % 16) != 0 || SLOT_CYC <= DEAD_CYC) begin : g_bad_cfg
        $error("scan_timebase: CLK_HZ/SCAN_HZ must be a multiple of 16 and exceed DEAD_CYC");
    end

    logic [SLOT_W-1:0]  slot_cnt;
    logic [SUB_W-1:0]   sub_cnt;
    logic [FRAME_W-1:0] frame_cnt;
    logic               slot_wrap;
    logic               sub_wrap;
    logic               frame_wrap;

    assign slot_wrap   = (slot_cnt == SLOT_W'(SLOT_CYC - 1));
    assign sub_wrap    = (sub_cnt == SUB_W'(SUB_CYC - 1));
    assign frame_wrap  = (frame_cnt == FRAME_W'(BLINK_FRAMES - 1));
    assign frame_start = (slot == SLOT_UNITS) && (slot_cnt == '0);
    assign dead        = (slot_cnt < SLOT_W'(DEAD_CYC));

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt  <= '0;
            sub_cnt   <= '0;
            sub_idx   <= '0;
            slot      <= SLOT_UNITS;
            frame_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            if (slot_wrap) begin
                slot_cnt <= '0;
                sub_cnt  <= '0;
                sub_idx  <= '0;
                slot     <= ~slot;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
                if (sub_wrap) begin
                    sub_cnt <= '0;
                    sub_idx <= sub_idx + 1'b1;
                end else begin
                    sub_cnt <= sub_cnt + 1'b1;
                end
            end
            // Leaving the tens slot is the edge into the next frame.
            if (slot_wrap && slot == SLOT_TENS) begin
                if (frame_wrap) begin
                    frame_cnt <= '0;
                    blink_ph  <= ~blink_ph;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed 7-segment driver: per-frame pattern capture, dead time,
// PWM brightness, leading-zero blanking and blinking, with registered outputs.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_HZ       = 12000000,
    parameter int SCAN_HZ      = 1000,
    parameter int DEAD_CYC     = 12,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] led_1,
    input  logic [8:0] led_2,
    input  logic [3:0] bright,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [8:0] seg_out,
    output logic [1:0] dig_n
);

    logic       frame_start;
    logic       dead;
    logic [3:0] sub_idx;
    logic       slot;
    logic       blink_ph;

    scan_timebase #(
        .CLK_HZ      (CLK_HZ),
        .SCAN_HZ     (SCAN_HZ),
        .DEAD_CYC    (DEAD_CYC),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_timebase (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .dead       (dead),
        .sub_idx    (sub_idx),
        .slot       (slot),
        .blink_ph   (blink_ph)
    );

    logic [8:0] u_pat;
    logic [8:0] t_pat;
    logic [8:0] u_cur;
    logic [8:0] t_cur;
    logic       lit;
    logic [8:0] seg_p0;
    logic [1:0] dig_p0;
    logic [8:0] seg_p1;
    logic [1:0] dig_p1;

    // Stage p0: on the frame-start cycle the latches are still loading, so
    // use the incoming patterns directly.
    always_comb begin
        u_cur  = frame_start ? led_1 : u_pat;
        t_cur  = frame_start ? led_2 : t_pat;
        lit    = !dead
               && (sub_idx <= bright)
               && !(blink_en && blink_ph)
               && !(slot == SLOT_TENS && blank_lz && t_cur == SEG_ZERO);
        seg_p0 = SEG_BLANK;
        dig_p0 = DIG_OFF;
        if (lit) begin
            dig_p0 = dig_select(slot);
            seg_p0 = (slot == SLOT_TENS) ? t_cur : u_cur;
        end
    end

    // Stage p1: registered segment bus and digit selects.
    always_ff @(posedge clk) begin
        if (rst) begin
            u_pat  <= SEG_BLANK;
            t_pat  <= SEG_BLANK;
            seg_p1 <= SEG_BLANK;
            dig_p1 <= DIG_OFF;
        end else begin
            if (frame_start) begin
                u_pat <= led_1;
                t_pat <= led_2;
            end
            seg_p1 <= seg_p0;
            dig_p1 <= dig_p0;
        end
    end

    assign seg_out = seg_p1;
    assign dig_n   = dig_p1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with a 16-cycle slot, 2-cycle dead time
// and 4-frame blink half-period.
module tb_seg_scan_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] led_1 = 9'h000;
    logic [8:0] led_2 = 9'h000;
    logic [3:0] bright = 4'd15;
    logic       blank_lz = 1'b0;
    logic       blink_en = 1'b0;
    logic [8:0] seg_out;
    logic [1:0] dig_n;

    seg_scan_driver #(
        .CLK_HZ      (1600),
        .SCAN_HZ     (100),
        .DEAD_CYC    (2),
        .BLINK_FRAMES(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .led_1   (led_1),
        .led_2   (led_2),
        .bright  (bright),
        .blank_lz(blank_lz),
        .blink_en(blink_en),
        .seg_out (seg_out),
        .dig_n   (dig_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [1:0] dig;
        logic [8:0] seg;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   base  = 0;

    localparam logic [1:0] DK = 2'b11;
    localparam logic [1:0] DU = 2'b10;
    localparam logic [1:0] DT = 2'b01;

    task automatic push(input int c0, input int c1, input logic [1:0] d, input logic [8:0] s);
        for (int c = c0; c <= c1; c++) sb.push_back('{cyc: base + c, dig: d, seg: s});
    endtask

    task automatic goto(input int k);
        while (cyc != base + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares each scheduled cycle and checks the digit selects every cycle.
    always @(negedge clk) begin
        tests++;
        if (dig_n == 2'b00) begin
            fails++;
            $display("FAIL dig_both_low cyc=%0d dig_n=%b required not 00", cyc, dig_n);
        end
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            tests++;
            fails++;
            $display("FAIL missed_cycle cyc=%0d required check at %0d", cyc, e.cyc);
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            tests++;
            if (dig_n !== e.dig || seg_out !== e.seg) begin
                fails++;
                $display("FAIL scan cyc=%0d rel=%0d got dig_n=%b seg=%h required dig_n=%b seg=%h",
                         cyc, cyc - base, dig_n, seg_out, e.dig, e.seg);
            end
        end
    end

    initial begin
        led_1 = 9'h006;
        led_2 = 9'h05b;
        repeat (3) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;

        // Reset/scan and frame capture
        push(0, 2, DK, 9'h000);
        push(3, 16, DU, 9'h006);
        push(17, 18, DK, 9'h000);
        push(19, 32, DT, 9'h05b);
        push(33, 34, DK, 9'h000);
        push(35, 48, DU, 9'h04f);
        // Brightness 5 in frame 2, brightness 0 in frame 3
        push(64, 66, DK, 9'h000);
        push(67, 70, DU, 9'h04f);
        push(71, 82, DK, 9'h000);
        push(83, 86, DT, 9'h05b);
        push(87, 127, DK, 9'h000);
        // Leading-zero blanking on, then off
        push(129, 130, DK, 9'h000);
        push(131, 144, DU, 9'h04f);
        push(145, 162, DK, 9'h000);
        push(163, 176, DU, 9'h04f);
        push(177, 178, DK, 9'h000);
        push(179, 192, DT, 9'h03f);
        // Blink: frames 6-7 dark, 8-11 normal, 12-13 dark
        push(193, 258, DK, 9'h000);
        push(259, 272, DU, 9'h04f);
        push(273, 274, DK, 9'h000);
        push(275, 288, DT, 9'h03f);
        push(381, 384, DT, 9'h03f);
        push(385, 425, DK, 9'h000);

        goto(10);
        led_1 = 9'h04f;
        goto(63);
        bright = 4'd5;
        goto(95);
        bright = 4'd0;
        goto(127);
        bright   = 4'd15;
        led_2    = 9'h03f;
        blank_lz = 1'b1;
        goto(160);
        blank_lz = 1'b0;
        goto(192);
        blink_en = 1'b1;

        // Mid-slot reset, then restart exactly as the first scan
        goto(424);
        rst      = 1'b1;
        blink_en = 1'b0;
        led_1    = 9'h006;
        led_2    = 9'h05b;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
        push(1, 2, DK, 9'h000);
        push(3, 16, DU, 9'h006);
        push(17, 18, DK, 9'h000);
        push(19, 32, DT, 9'h05b);
        push(33, 34, DK, 9'h000);
        push(35, 48, DU, 9'h006);

        goto(52);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
